// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM states and ALU function codes.
// The optional return stack is enabled with the ACC_CPU_CALL_EN macro.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_INP  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_EXEC, S_MEM, S_IN_WAIT, S_OUT_WAIT, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_NONE
    } alu_fn_t;

    // ST is the only memory op that leaves ACC alone.
    function automatic alu_fn_t alu_fn_of(input logic [3:0] op);
        case (op)
            OP_LD:   return ALU_PASS;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_XOR:  return ALU_XOR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/acc_cpu_core_rstack.sv
// Circular return stack: a push on a full stack overwrites the oldest entry and the
// occupancy count saturates at DEPTH; DEPTH must be a power of two.
module acc_cpu_rstack
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW:0]      r_cnt;
    logic [PW-1:0]    w_rp;

    assign w_rp    = r_wp - PW'(1);
    assign o_top   = r_mem[w_rp];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_wp <= r_wp + PW'(1);
            if (!o_full)
                r_cnt <= r_cnt + (PW+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_wp  <= w_rp;
            r_cnt <= r_cnt - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with req/ack memories and valid/ready I/O.
// Define ACC_CPU_CALL_EN to turn opcodes D/E into RET/CALL backed by a return stack.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
)(
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [ADDR_W+3:0] imem_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              inp_valid_i,
    input  logic [DATA_W-1:0] inp_data_i,
    output logic              inp_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              halted_o,
    output logic [DATA_W-1:0] acc_o
);
    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic                r_z;
    logic                r_c;
    logic [ADDR_W+3:0]   r_ir;
    logic [DATA_W-1:0]   r_out_data;

    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_operand;
    logic [ADDR_W-1:0]   w_pc_inc;
    alu_fn_t             w_alu_fn;
    logic [DATA_W:0]     w_alu_res;

    assign w_op      = r_ir[ADDR_W+3:ADDR_W];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_alu_fn  = alu_fn_of(w_op);

`ifdef ACC_CPU_CALL_EN
    logic                w_rs_push;
    logic                w_rs_pop;
    logic [ADDR_W-1:0]   w_rs_top;
    logic                w_rs_empty;
    logic                w_rs_full;

    assign w_rs_push = (r_state == S_EXEC) && (w_op == OP_CALL);
    assign w_rs_pop  = (r_state == S_EXEC) && (w_op == OP_RET);

    acc_cpu_rstack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_rstack (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_rs_push),
        .i_pop   (w_rs_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_rs_top),
        .o_empty (w_rs_empty),
        .o_full  (w_rs_full)
    );
`endif

    // Carry-out of ADD and borrow of SUB both land in the extra top bit.
    always_comb begin
        w_alu_res = {r_c, r_acc};
        case (w_alu_fn)
            ALU_PASS: w_alu_res = {r_c, dmem_rdata_i};
            ALU_ADD:  w_alu_res = {1'b0, r_acc} + {1'b0, dmem_rdata_i};
            ALU_SUB:  w_alu_res = {1'b0, r_acc} - {1'b0, dmem_rdata_i};
            ALU_AND:  w_alu_res = {r_c, r_acc & dmem_rdata_i};
            ALU_XOR:  w_alu_res = {r_c, r_acc ^ dmem_rdata_i};
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_BOOT;
            r_pc       <= '0;
            r_acc      <= '0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_ir       <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_BOOT: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack_i) begin
                        r_ir    <= imem_data_i;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    r_pc    <= w_pc_inc;
                    case (w_op)
                        OP_LDI: begin
                            r_acc <= w_operand[DATA_W-1:0];
                            r_z   <= (w_operand[DATA_W-1:0] == '0);
                        end
                        OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                            r_state <= S_MEM;
                            r_pc    <= r_pc;
                        end
                        OP_INP: begin
                            r_state <= S_IN_WAIT;
                            r_pc    <= r_pc;
                        end
                        OP_OUT: begin
                            r_out_data <= r_acc;
                            r_state    <= S_OUT_WAIT;
                            r_pc       <= r_pc;
                        end
                        OP_JMP: r_pc <= w_operand;
                        OP_JZ:  if (r_z) r_pc <= w_operand;
                        OP_JC:  if (r_c) r_pc <= w_operand;
`ifdef ACC_CPU_CALL_EN
                        OP_RET:  if (!w_rs_empty) r_pc <= w_rs_top;
                        OP_CALL: r_pc <= w_operand;
`endif
                        OP_HLT: begin
                            r_state <= S_HALT;
                            r_pc    <= r_pc;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        if (w_alu_fn != ALU_NONE) begin
                            r_acc <= w_alu_res[DATA_W-1:0];
                            r_z   <= (w_alu_res[DATA_W-1:0] == '0);
                        end
                        if (w_alu_fn == ALU_ADD || w_alu_fn == ALU_SUB)
                            r_c <= w_alu_res[DATA_W];
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_IN_WAIT: begin
                    if (inp_valid_i) begin
                        r_acc   <= inp_data_i;
                        r_z     <= (inp_data_i == '0);
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready_i) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT:  ;
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign imem_req_o   = (r_state == S_FETCH);
    assign imem_addr_o  = r_pc;
    assign dmem_req_o   = (r_state == S_MEM);
    assign dmem_we_o    = (r_state == S_MEM) && (w_op == OP_ST);
    assign dmem_addr_o  = w_operand;
    assign dmem_wdata_o = r_acc;
    assign inp_ready_o  = (r_state == S_IN_WAIT);
    assign out_valid_o  = (r_state == S_OUT_WAIT);
    assign out_data_o   = r_out_data;
    assign halted_o     = (r_state == S_HALT);
    assign acc_o        = r_acc;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: an instruction-level reference model predicts the
// fetch trace, data accesses and output words; a monitor compares them as the DUT runs.
module tb_acc_cpu_core;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int IW = AW + 4;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          imem_req_o, imem_ack_i;
    logic [AW-1:0] imem_addr_o;
    logic [IW-1:0] imem_data_i;
    logic          dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [AW-1:0] dmem_addr_o;
    logic [DW-1:0] dmem_wdata_o, dmem_rdata_i;
    logic          inp_valid_i, inp_ready_o;
    logic [DW-1:0] inp_data_i;
    logic          out_valid_o, out_ready_i, halted_o;
    logic [DW-1:0] out_data_o, acc_o;

    always #5 clk_i = ~clk_i;

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .inp_valid_i(inp_valid_i), .inp_data_i(inp_data_i), .inp_ready_o(inp_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .halted_o(halted_o), .acc_o(acc_o)
    );

    logic [IW-1:0] imem [4096];
    logic [DW-1:0] dmem [4096];
    int            inq [$];

    typedef struct { int pc; int acc; } fetch_t;
    typedef struct { int we; int addr; int wdata; } dacc_t;
    fetch_t exp_f [$];
    dacc_t  exp_d [$];
    int     exp_o [$];

    int errors = 0;
    int checks = 0;
    int imem_wait = -1, dmem_wait = -1, inp_wait = -1, out_wait = -1;
    bit run_active = 0;
    bit d_busy = 0;
    int d_pc, d_acc;
    int o_cycles = 0, last_out_cycles = 0, last_out = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Instruction memory: ack after 0..2 wait cycles (or a forced count).
    initial begin
        int w; bit busy;
        imem_ack_i = 0; imem_data_i = '0; busy = 0; w = 0;
        forever begin
            @(posedge clk_i); #1;
            imem_ack_i = 0;
            if (imem_req_o) begin
                if (!busy) begin busy = 1; w = (imem_wait < 0) ? int'($urandom_range(0, 2)) : imem_wait; end
                if (w == 0) begin imem_ack_i = 1; imem_data_i = imem[imem_addr_o]; busy = 0; end
                else w--;
            end else busy = 0;
        end
    end

    initial begin
        int w; bit busy;
        dmem_ack_i = 0; dmem_rdata_i = '0; busy = 0; w = 0;
        forever begin
            @(posedge clk_i); #1;
            dmem_ack_i = 0;
            if (dmem_req_o) begin
                if (!busy) begin busy = 1; w = (dmem_wait < 0) ? int'($urandom_range(0, 3)) : dmem_wait; end
                if (w == 0) begin
                    dmem_ack_i = 1; busy = 0;
                    if (dmem_we_o) dmem[dmem_addr_o] = dmem_wdata_o;
                    else dmem_rdata_i = dmem[dmem_addr_o];
                end else w--;
            end else busy = 0;
        end
    end

    initial begin
        int w; bit busy;
        inp_valid_i = 0; inp_data_i = '0; busy = 0; w = 0;
        forever begin
            @(posedge clk_i); #1;
            inp_valid_i = 0;
            if (inp_ready_o) begin
                if (!busy) begin busy = 1; w = (inp_wait < 0) ? int'($urandom_range(0, 4)) : inp_wait; end
                if (w == 0) begin
                    inp_valid_i = 1; busy = 0;
                    inp_data_i = (inq.size() > 0) ? DW'(inq.pop_front()) : '0;
                end else w--;
            end else busy = 0;
        end
    end

    initial begin
        int w; bit busy;
        out_ready_i = 0; busy = 0; w = 0;
        forever begin
            @(posedge clk_i); #1;
            out_ready_i = 0;
            if (out_valid_o) begin
                if (!busy) begin busy = 1; w = (out_wait < 0) ? int'($urandom_range(0, 3)) : out_wait; end
                if (w == 0) begin out_ready_i = 1; busy = 0; end
                else w--;
            end else busy = 0;
        end
    end

    // Monitor: pops the scoreboard whenever a handshake is about to complete.
    initial begin
        fetch_t f; dacc_t d;
        forever begin
            @(negedge clk_i);
            if (rst_ni && run_active) begin
                if (imem_req_o && imem_ack_i) begin
                    if (exp_f.size() == 0) check("fetch_unexpected", int'(imem_addr_o), -1);
                    else begin
                        f = exp_f.pop_front();
                        check("fetch_pc", int'(imem_addr_o), f.pc);
                        check("fetch_acc", int'(acc_o), f.acc);
                    end
                end
                if (dmem_req_o) begin
                    if (!d_busy) begin d_busy = 1; d_pc = int'(imem_addr_o); d_acc = int'(acc_o); end
                    else begin
                        check("stall_pc", int'(imem_addr_o), d_pc);
                        check("stall_acc", int'(acc_o), d_acc);
                    end
                    if (dmem_ack_i) begin
                        d_busy = 0;
                        if (exp_d.size() == 0) check("dmem_unexpected", int'(dmem_addr_o), -1);
                        else begin
                            d = exp_d.pop_front();
                            check("dmem_we", int'(dmem_we_o), d.we);
                            check("dmem_addr", int'(dmem_addr_o), d.addr);
                            if (d.we != 0) check("dmem_wdata", int'(dmem_wdata_o), d.wdata);
                        end
                    end
                end
                if (out_valid_o) begin
                    o_cycles++;
                    if (out_ready_i) begin
                        if (exp_o.size() == 0) check("out_unexpected", int'(out_data_o), -1);
                        else begin
                            last_out = exp_o.pop_front();
                            check("out_data", int'(out_data_o), last_out);
                        end
                        last_out_cycles = o_cycles;
                        o_cycles = 0;
                    end
                end
            end
        end
    end

    // Instruction-level reference model, run ahead of the DUT over the loaded program.
    task automatic model_run(output int facc, output bit fhalt);
        int pc, acc, z, c, nxt, op, opr, t, m;
        int ins_in [$];
        int stk [$];
        logic [DW-1:0] md [4096];
        logic [IW-1:0] ins;
        fetch_t f; dacc_t d;
        pc = 0; acc = 0; z = 0; c = 0; fhalt = 0;
        md = dmem;
        ins_in = inq;
        for (int step = 0; step < 600 && !fhalt; step++) begin
            ins = imem[pc];
            op  = int'(ins[IW-1:AW]);
            opr = int'(ins[AW-1:0]);
            m   = int'(md[opr]);
            f.pc = pc; f.acc = acc; exp_f.push_back(f);
            nxt = (pc + 1) % 4096;
            case (op)
                1:  begin acc = opr % 256; z = (acc == 0); end
                2:  begin d.we = 0; d.addr = opr; d.wdata = 0; exp_d.push_back(d); acc = m; z = (acc == 0); end
                3:  begin d.we = 1; d.addr = opr; d.wdata = acc; exp_d.push_back(d); md[opr] = DW'(acc); end
                4:  begin d.we = 0; d.addr = opr; d.wdata = 0; exp_d.push_back(d);
                          t = acc + m; c = (t > 255); acc = t & 255; z = (acc == 0); end
                5:  begin d.we = 0; d.addr = opr; d.wdata = 0; exp_d.push_back(d);
                          t = acc - m; c = (t < 0); acc = t & 255; z = (acc == 0); end
                6:  begin d.we = 0; d.addr = opr; d.wdata = 0; exp_d.push_back(d); acc = acc & m; z = (acc == 0); end
                7:  begin d.we = 0; d.addr = opr; d.wdata = 0; exp_d.push_back(d); acc = acc ^ m; z = (acc == 0); end
                8:  begin acc = (ins_in.size() > 0) ? ins_in.pop_front() : 0; z = (acc == 0); end
                9:  exp_o.push_back(acc);
                10: nxt = opr;
                11: if (z != 0) nxt = opr;
                12: if (c != 0) nxt = opr;
`ifdef ACC_CPU_CALL_EN
                13: if (stk.size() > 0) nxt = stk.pop_back();
                14: begin
                        if (stk.size() == DEPTH) void'(stk.pop_front());
                        stk.push_back((pc + 1) % 4096);
                        nxt = opr;
                    end
`endif
                15: fhalt = 1;
                default: ;
            endcase
            if (!fhalt) pc = nxt;
        end
        facc = acc;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin imem[i] = '0; dmem[i] = '0; end
        inq.delete();
    endtask

    task automatic run_prog(input string name, input int budget);
        int facc; bit fhalt; int cyc;
        @(negedge clk_i);
        rst_ni = 0; run_active = 0;
        exp_f.delete(); exp_d.delete(); exp_o.delete();
        d_busy = 0; o_cycles = 0; last_out_cycles = 0;
        repeat (3) @(negedge clk_i);
        model_run(facc, fhalt);
        run_active = 1;
        rst_ni = 1;
        check({name, "_boot_req"}, int'(imem_req_o), 0);
        @(negedge clk_i);
        check({name, "_fetch0_addr"}, int'(imem_req_o) * 4096 + int'(imem_addr_o), 4096);
        cyc = 0;
        while (!halted_o && cyc < budget) begin @(negedge clk_i); cyc++; end
        if (fhalt) check({name, "_halted"}, int'(halted_o), 1);
        repeat (3) @(negedge clk_i);
        check({name, "_halt_noreq"}, int'(imem_req_o), 0);
        check({name, "_final_acc"}, int'(acc_o), facc);
        check({name, "_pending"}, exp_f.size() + exp_d.size() + exp_o.size(), 0);
        run_active = 0;
        imem_wait = -1; dmem_wait = -1; inp_wait = -1; out_wait = -1;
    endtask

    task automatic gen_random();
        logic [3:0] o; logic [11:0] a; int op;
        clear_mem();
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 14));
`ifdef ACC_CPU_CALL_EN
            if (op == 13 || op == 14) op = 0;
`endif
            if (op >= 2 && op <= 7) a = 12'($urandom_range(0, 15));
            else if (op >= 10 && op <= 12) a = 12'($urandom_range(i + 1, 40));
            else a = 12'($urandom_range(0, 4095));
            o = 4'(op);
            imem[i] = {o, a};
        end
        imem[40] = 16'hF000;
        for (int i = 0; i < 16; i++) dmem[i] = DW'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) inq.push_back(int'($urandom_range(0, 255)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        clear_mem();
        rst_ni = 0;
        repeat (3) @(negedge clk_i);
        check("rst_imem_req", int'(imem_req_o), 0);
        check("rst_dmem_req", int'(dmem_req_o), 0);
        check("rst_dmem_we", int'(dmem_we_o), 0);
        check("rst_inp_ready", int'(inp_ready_o), 0);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_halted", int'(halted_o), 0);
        check("rst_acc", int'(acc_o), 0);
        check("rst_out_data", int'(out_data_o), 0);

        // Arithmetic and flags: ADD carries, SUB borrows.
        clear_mem();
        dmem[5] = 8'h20;
        imem[0] = 16'h10F0; imem[1] = 16'h4005; imem[2] = 16'hC004; imem[3] = 16'hF000;
        imem[4] = 16'h9000; imem[5] = 16'h5005; imem[6] = 16'hC008; imem[7] = 16'hF000;
        imem[8] = 16'h9000; imem[9] = 16'hB003; imem[10] = 16'hF000;
        run_prog("arith", 400);

        // Data wait states on LD and ST.
        clear_mem();
        dmem[9] = 8'hA5;
        imem[0] = 16'h1003; imem[1] = 16'h2009; imem[2] = 16'h300A; imem[3] = 16'h9000; imem[4] = 16'hF000;
        dmem_wait = 4;
        run_prog("waitst", 400);
        check("waitst_stored", int'(dmem[10]), 8'hA5);

        // I/O handshakes: late input, back-pressured output.
        clear_mem();
        imem[0] = 16'h8000; imem[1] = 16'h9000; imem[2] = 16'hF000;
        inq.push_back(8'h3C);
        inp_wait = 5; out_wait = 2; imem_wait = 0;
        run_prog("io", 400);
        check("io_out_cycles", last_out_cycles, 3);
        check("io_out_hold", int'(out_data_o), 8'h3C);

        // JZ taken then not taken.
        clear_mem();
        imem[0] = 16'h1000; imem[1] = 16'hB004; imem[2] = 16'hF000; imem[3] = 16'hF000;
        imem[4] = 16'h1001; imem[5] = 16'hB002; imem[6] = 16'h9000; imem[7] = 16'hF000;
        run_prog("jz", 400);

        // PC wrap from 0xFFF to 0x000, JC taken on the second pass.
        clear_mem();
        dmem[7] = 8'hFF;
        imem[0] = 16'hC010; imem[1] = 16'h1001; imem[2] = 16'hAFFF; imem[12'hFFF] = 16'h4007;
        imem[12'h010] = 16'h9000; imem[12'h011] = 16'hF000;
        run_prog("wrap", 400);

`ifdef ACC_CPU_CALL_EN
        clear_mem();
        imem[12'h000] = 16'hE010; imem[12'h010] = 16'hE020; imem[12'h020] = 16'hE030;
        imem[12'h030] = 16'hE040; imem[12'h040] = 16'hE050;
        imem[12'h050] = 16'hD000; imem[12'h041] = 16'hD000; imem[12'h031] = 16'hD000;
        imem[12'h021] = 16'hD000; imem[12'h011] = 16'hD000; imem[12'h012] = 16'hF000;
        run_prog("call", 400);
`else
        clear_mem();
        imem[0] = 16'h1007; imem[1] = 16'hE055; imem[2] = 16'hD033; imem[3] = 16'h9000; imem[4] = 16'hF000;
        run_prog("nop_de", 400);
`endif

        for (int r = 0; r < 6; r++) begin
            gen_random();
            run_prog("rand", 3000);
        end

        // Reset in the middle of a data request drops the request at once.
        clear_mem();
        imem[0] = 16'h2003; imem[1] = 16'hF000;
        dmem_wait = 10;
        @(negedge clk_i);
        rst_ni = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        cyc = 0;
        while (!dmem_req_o && cyc < 20) begin @(negedge clk_i); cyc++; end
        check("midrst_req_seen", int'(dmem_req_o), 1);
        #2 rst_ni = 0;
        #1;
        check("midrst_dmem_req", int'(dmem_req_o), 0);
        check("midrst_imem_req", int'(imem_req_o), 0);
        @(negedge clk_i);
        dmem_wait = -1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
